// File: rtl/pbs_battle_datapath.sv
// Battle datapath: true/animated HP for player and AI, damage/heal/catch commands, death and catch flags.
// Optional critical hits are enabled by defining PBS_CRIT_EN.
module pbs_battle_datapath #(
    parameter int         HP_W         = 8,
    parameter int         P_MAX_HP     = 100,
    parameter int         AI_MAX_HP    = 100,
    parameter int         P_ATK        = 12,
    parameter int         AI_ATK       = 10,
    parameter int         HEAL_AMT     = 20,
    parameter int         CATCH_THRESH = 32,
    parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            load,
    input  logic            active_trainer,
    input  logic            target,
    input  logic            apply_ai_damage,
    input  logic            apply_p_damage,
    input  logic            p_heal,
    input  logic            catch,
    output logic [HP_W-1:0] p_hp,
    output logic [HP_W-1:0] ai_hp,
    output logic [HP_W-1:0] p_hp_disp,
    output logic [HP_W-1:0] ai_hp_disp,
    output logic            anim_busy,
    output logic            p_dead,
    output logic            ai_dead,
    output logic            catch_success,
    output logic            cmd_err,
    output logic            crit,
    output logic            frozen_dbg
);
    typedef enum logic {ACTIVE = 1'b0, FROZEN = 1'b1} phase_t;

    localparam logic [HP_W:0]   P_MAX_X   = (HP_W+1)'(P_MAX_HP);
    localparam logic [HP_W-1:0] P_MAX_V   = HP_W'(P_MAX_HP);
    localparam logic [HP_W-1:0] AI_MAX_V  = HP_W'(AI_MAX_HP);
    localparam logic [HP_W:0]   P_ATK_X   = (HP_W+1)'(P_ATK);
    localparam logic [HP_W:0]   AI_ATK_X  = (HP_W+1)'(AI_ATK);
    localparam logic [HP_W:0]   HEAL_X    = (HP_W+1)'(HEAL_AMT);
    localparam logic [HP_W-1:0] ONE       = HP_W'(1);

    phase_t          phase_q, phase_d;
    logic [HP_W-1:0] p_hp_q, p_hp_d, ai_hp_q, ai_hp_d;
    logic [HP_W-1:0] p_disp_q, p_disp_d, ai_disp_q, ai_disp_d;
    logic            catch_q, catch_d, err_q, err_d, crit_q, crit_d, crit_roll;
    logic [7:0]      lfsr_q, lfsr_d;
    logic [HP_W:0]   dmg_base, dmg;
    logic [2:0]      n_strobes;
    logic [9:0]      thr_x, thr_sat;

    function automatic logic [HP_W-1:0] toward(input logic [HP_W-1:0] disp, input logic [HP_W-1:0] hp);
        if (disp < hp) return disp + ONE;
        if (disp > hp) return disp - ONE;
        return disp;
    endfunction

    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp, input logic [HP_W:0] d);
        logic [HP_W:0] hx, diff;
        hx   = {1'b0, hp};
        diff = hx - d;
        return (hx > d) ? diff[HP_W-1:0] : '0;
    endfunction

    function automatic logic [HP_W-1:0] heal_add(input logic [HP_W-1:0] hp);
        logic [HP_W:0] sum;
        sum = {1'b0, hp} + HEAL_X;
        return (sum > P_MAX_X) ? P_MAX_V : sum[HP_W-1:0];
    endfunction

    always_comb begin
        lfsr_d    = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        p_hp_d    = p_hp_q;
        ai_hp_d   = ai_hp_q;
        p_disp_d  = toward(p_disp_q, p_hp_q);
        ai_disp_d = toward(ai_disp_q, ai_hp_q);
        catch_d   = catch_q;
        err_d     = err_q;
        phase_d   = phase_q;
        crit_d    = 1'b0;
`ifdef PBS_CRIT_EN
        crit_roll = (lfsr_q[2:0] == 3'b111);
`else
        crit_roll = 1'b0;
`endif
        dmg_base  = active_trainer ? AI_ATK_X : P_ATK_X;
        dmg       = crit_roll ? (dmg_base << 1) : dmg_base;
        n_strobes = 3'(load) + 3'(apply_ai_damage) + 3'(apply_p_damage) + 3'(p_heal) + 3'(catch);
        // Missing HP raises the catch odds; the sum can exceed 8 bits so it saturates.
        thr_x     = 10'(CATCH_THRESH) + 10'(AI_MAX_HP) - 10'(ai_hp_q);
        thr_sat   = (thr_x > 10'd255) ? 10'd255 : thr_x;

        if (load) begin
            p_hp_d    = P_MAX_V;
            ai_hp_d   = AI_MAX_V;
            p_disp_d  = P_MAX_V;
            ai_disp_d = AI_MAX_V;
            catch_d   = 1'b0;
            err_d     = 1'b0;
            phase_d   = ACTIVE;
        end else begin
            if (n_strobes > 3'd1 || (apply_ai_damage && !target) || (apply_p_damage && target))
                err_d = 1'b1;
            if (phase_q == ACTIVE) begin
                if (apply_ai_damage) begin
                    ai_hp_d = sat_sub(ai_hp_q, dmg);
                    crit_d  = crit_roll;
                end else if (apply_p_damage) begin
                    p_hp_d = sat_sub(p_hp_q, dmg);
                    crit_d = crit_roll;
                end else if (p_heal) begin
                    p_hp_d = heal_add(p_hp_q);
                end else if (catch) begin
                    catch_d = ({2'b00, lfsr_q} < thr_sat);
                end
                if (ai_hp_d == '0 || p_hp_d == '0 || catch_d)
                    phase_d = FROZEN;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q   <= ACTIVE;
            p_hp_q    <= P_MAX_V;
            ai_hp_q   <= AI_MAX_V;
            p_disp_q  <= P_MAX_V;
            ai_disp_q <= AI_MAX_V;
            catch_q   <= 1'b0;
            err_q     <= 1'b0;
            crit_q    <= 1'b0;
            lfsr_q    <= LFSR_SEED;
        end else begin
            phase_q   <= phase_d;
            p_hp_q    <= p_hp_d;
            ai_hp_q   <= ai_hp_d;
            p_disp_q  <= p_disp_d;
            ai_disp_q <= ai_disp_d;
            catch_q   <= catch_d;
            err_q     <= err_d;
            crit_q    <= crit_d;
            lfsr_q    <= lfsr_d;
        end
    end

    assign p_hp          = p_hp_q;
    assign ai_hp         = ai_hp_q;
    assign p_hp_disp     = p_disp_q;
    assign ai_hp_disp    = ai_disp_q;
    assign anim_busy     = (p_disp_q != p_hp_q) | (ai_disp_q != ai_hp_q);
    assign p_dead        = (p_hp_q == '0);
    assign ai_dead       = (ai_hp_q == '0);
    assign catch_success = catch_q;
    assign cmd_err       = err_q;
    assign crit          = crit_q;
    assign frozen_dbg    = (phase_q == FROZEN);
endmodule

// File: doc/pbs_battle_datapath.md
Name: pbs_battle_datapath

Overview:
- Battle datapath that responds to the battle control FSM's strobes.
- Holds player and AI Pokemon HP and applies damage, heal and catch commands.
- Returns the status flags the FSM branches on: ai_dead, p_dead, catch_success.
- Also drives animated display HP counters for the VGA/HEX front end.

Parameters:
- HP_W, 8, width of all HP registers.
- P_MAX_HP, 100, player starting/max HP.
- AI_MAX_HP, 100, AI starting/max HP.
- P_ATK, 12, damage dealt when active_trainer=0.
- AI_ATK, 10, damage dealt when active_trainer=1.
- HEAL_AMT, 20, HP restored by p_heal.
- CATCH_THRESH, 32, base catch threshold (0..255).
- LFSR_SEED, 8'hA5, nonzero reset value of the catch/crit LFSR.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- load  in  1  one-cycle strobe: restart battle, reload max HP, clear flags
- active_trainer  in  1  0=player attacking, 1=AI attacking
- target  in  1  0=player Pokemon, 1=AI Pokemon
- apply_ai_damage  in  1  strobe: subtract attacker damage from ai_hp
- apply_p_damage  in  1  strobe: subtract attacker damage from p_hp
- p_heal  in  1  strobe: add HEAL_AMT to p_hp
- catch  in  1  strobe: roll catch attempt
- p_hp  out  HP_W  true player HP
- ai_hp  out  HP_W  true AI HP
- p_hp_disp  out  HP_W  animated player HP
- ai_hp_disp  out  HP_W  animated AI HP
- anim_busy  out  1  either display counter differs from its true HP
- p_dead  out  1  p_hp==0
- ai_dead  out  1  ai_hp==0
- catch_success  out  1  sticky: last catch succeeded
- cmd_err  out  1  sticky protocol error
- crit  out  1  one-cycle pulse on a critical hit (optional feature only)

Behaviour:
- Reset (async, reset_n=0):
  - p_hp=p_hp_disp=P_MAX_HP; ai_hp=ai_hp_disp=AI_MAX_HP.
  - catch_success=0, cmd_err=0, crit=0, lfsr=LFSR_SEED.
  - frozen=0. p_dead and ai_dead are 0 as a consequence of the HP values.
- State: the registered battle phase is ACTIVE or FROZEN.
  - FROZEN is entered on the edge where ai_hp or p_hp becomes 0, or where catch_success sets.
  - In FROZEN all damage/heal/catch strobes are ignored. Only load leaves FROZEN.
- Command priority, evaluated each edge: load > apply_ai_damage > apply_p_damage > p_heal > catch. Only the highest-priority asserted strobe acts.
- More than one strobe high in the same cycle sets cmd_err (sticky until reset or load).
- Damage amount:
  - dmg = active_trainer ? AI_ATK : P_ATK.
  - Computed in HP_W+1 bits. Result = (hp > dmg) ? hp-dmg : 0, i.e. saturates at 0 with no wrap.
- target check: apply_ai_damage with target!=1, or apply_p_damage with target!=0, sets cmd_err. The damage is still applied per the strobe.
- Heal: p_hp = min(p_hp+HEAL_AMT, P_MAX_HP), computed in HP_W+1 bits.
- Latency: true HP updates on the clock edge that samples the strobe. ai_dead/p_dead are combinational from the registered HP, so they are valid in the cycle after the strobe.
- Catch:
  - thr = CATCH_THRESH + (AI_MAX_HP - ai_hp), computed 9-bit and saturated at 255.
  - On the catch edge: catch_success <= (lfsr < thr). A failure leaves catch_success=0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Steps every cycle while reset_n=1 and never reaches 0.
- Display HP:
  - Each cycle, each *_disp moves 1 toward its true HP.
  - anim_busy = (p_hp_disp!=p_hp) | (ai_hp_disp!=ai_hp).
  - On load, both *_disp snap to max immediately, with no animation.
- load: HP to max, frozen=0, catch_success=0, cmd_err=0, all in one edge. The LFSR is not reseeded.
- Simultaneous death and catch is impossible, because the strobes are exclusive by priority.

Optional Feature:
- Macro: PBS_CRIT_EN.
- Defined:
  - On a damage strobe, if lfsr[2:0]==3'b111, dmg is doubled (HP_W+1-bit, still saturating).
  - crit pulses high for exactly one cycle, the cycle after the strobe.
- Undefined: no doubling; crit is tied to 0.

Test Plan:
- Reset, then release -> p_hp=100, ai_hp=100, disp=100, ai_dead=p_dead=0, anim_busy=0.
- apply_ai_damage with active_trainer=0, target=1 -> ai_hp=88 next cycle; ai_hp_disp steps 100..88 over 12 cycles; anim_busy high exactly 12 cycles.
- Nine apply_ai_damage strobes (P_ATK=12) -> 8th leaves ai_hp=4; 9th gives ai_hp=0 (saturates, no wrap), ai_dead=1 and FROZEN. Further apply_p_damage leaves p_hp unchanged. load -> hp=100, ai_dead=0.
- apply_p_damage with active_trainer=1, target=0 -> p_hp=90. p_heal -> 100 (clamped, not 110). Then apply_p_damage+p_heal in the same cycle -> p_hp=90, cmd_err=1.
- catch with CATCH_THRESH=255 -> catch_success=1 and frozen. catch with CATCH_THRESH=0 at ai_hp=100 -> catch_success=0, battle continues.
- Assert reset_n low mid-animation, asynchronously between clock edges -> all outputs at reset values immediately, before the next clk edge.
